// File: rtl/encoder.sv
// ---------------------------------------------------------------------------
// encoder
//   Serialises one command frame into a UART byte stream.  A frame is a
//   header byte (the command) followed by its payload, sent least
//   significant byte first from a shift buffer.
//
//   CMD_DATA (8'h0A+1 = 8'h0B): PACK_NUM payload bytes
//     output_pattern_i, then {sel_out_i, 1'b0, mode_i, stop_bit_i, start_bit_i}
//   CMD_FREQ (8'h0A): FREQ_NUM payload bytes
//     freq_pattern_i, then slow_period_i, then fast_period_i
//
// Ports
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   start_i, cmd_i         one-cycle frame request and its command
//   output_pattern_i,
//   sel_out_i, start_bit_i,
//   stop_bit_i, mode_i     data-frame fields
//   freq_pattern_i,
//   slow_period_i,
//   fast_period_i          freq-frame fields
//   tx_done_tick_i         transmitter finished the current byte
//   tx_data_o, tx_start_o  byte to send and its one-cycle launch pulse
//   busy_o, done_tick_o    frame in progress / frame complete pulse
//   state_o                current FSM state (debug observation)
//
// Handshakes
//   Request side: start_i is sampled only while busy_o is 0 (state S_IDLE);
//   a request with a valid command is accepted on that edge and every input
//   field is captured, so inputs are don't-care afterwards.  Requests while
//   busy_o is 1 are dropped, not queued.
//   Transmit side: tx_start_o pulses one cycle with tx_data_o valid;
//   tx_data_o then holds until tx_done_tick_i is seen in S_WAIT.  A
//   tx_done_tick_i in any other state is ignored.
// ---------------------------------------------------------------------------
module encoder #(
  parameter int DATA_BIT = 32,
  parameter int PACK_NUM = 5,
  parameter int FREQ_NUM = 6
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                start_i,
  input  logic [7:0]          cmd_i,
  input  logic [DATA_BIT-1:0] output_pattern_i,
  input  logic [3:0]          sel_out_i,
  input  logic                start_bit_i,
  input  logic                stop_bit_i,
  input  logic                mode_i,
  input  logic [DATA_BIT-1:0] freq_pattern_i,
  input  logic [7:0]          slow_period_i,
  input  logic [7:0]          fast_period_i,
  input  logic                tx_done_tick_i,
  output logic [7:0]          tx_data_o,
  output logic                tx_start_o,
  output logic                busy_o,
  output logic                done_tick_o,
  output logic [1:0]          state_o
);

  localparam logic [7:0] CMD_FREQ = 8'h0A;
  localparam logic [7:0] CMD_DATA = 8'h0B;
  localparam int MAX_PAY = (PACK_NUM > FREQ_NUM) ? PACK_NUM : FREQ_NUM;
  // Header byte lives in the low byte of the buffer so one shifter serves
  // both the header and the payload.
  localparam int BUF_W   = 8 * (MAX_PAY + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           state_q;
  logic [BUF_W-1:0] buf_q;
  logic [3:0]       cnt_q;
  logic [7:0]       cmd_q;
  logic             tx_start_q;
  logic             busy_q;
  logic             done_q;

  logic             cmd_ok;
  logic [7:0]       ctrl_byte;
  logic [BUF_W-1:0] data_frame;
  logic [BUF_W-1:0] freq_frame;
  logic [3:0]       last_idx;

  assign cmd_ok     = (cmd_i == CMD_DATA) || (cmd_i == CMD_FREQ);
  assign ctrl_byte  = {sel_out_i, 1'b0, mode_i, stop_bit_i, start_bit_i};
  assign data_frame = BUF_W'({ctrl_byte, output_pattern_i, CMD_DATA});
  assign freq_frame = BUF_W'({fast_period_i, slow_period_i, freq_pattern_i, CMD_FREQ});

  // Index of the final byte of the frame (header is index 0).
  assign last_idx   = (cmd_q == CMD_DATA) ? 4'(PACK_NUM) : 4'(FREQ_NUM);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      buf_q      <= '0;
      cnt_q      <= '0;
      cmd_q      <= '0;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i && cmd_ok) begin
            cmd_q      <= cmd_i;
            buf_q      <= (cmd_i == CMD_DATA) ? data_frame : freq_frame;
            cnt_q      <= '0;
            tx_start_q <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= S_SEND;
          end
        end
        S_SEND: begin
          // The launch pulse was raised on entry; drop it after one cycle.
          tx_start_q <= 1'b0;
          state_q    <= S_WAIT;
        end
        S_WAIT: begin
          if (tx_done_tick_i) begin
            buf_q <= buf_q >> 8;
            cnt_q <= cnt_q + 4'd1;
            if (cnt_q == last_idx) begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              tx_start_q <= 1'b1;
              state_q    <= S_SEND;
            end
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign tx_data_o   = buf_q[7:0];
  assign tx_start_o  = tx_start_q;
  assign busy_o      = busy_q;
  assign done_tick_o = done_q;
  assign state_o     = state_q;

endmodule
